cv32e40p_obi_ahb_bridge: RTL and testbench
==========================================

# cv32e40p_obi_ahb_bridge

Parametrised multi-port bridge from CV32E40P OBI-style request/grant/rvalid interfaces (instruction, data, optional extra masters) to a single AHB-Lite master port. Sits between the core (and any debug/DMA requester) and the AHB interconnect in the testbench wrapper, replacing direct core-to-RAM wiring. Adds arbitration, pipelined AHB address/data phases, wait-state handling and bus-error reporting.

## Interface
- NUM_PORTS, 2, number of OBI requesters; port 0 = instruction, port 1 = data
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (32 only supported)
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round robin
- INSTR_PORT_MASK, 'b01, bit p set -> port p issues opcode-fetch HPROT
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- req_i  in  NUM_PORTS  OBI request per port
- gnt_o  out  NUM_PORTS  OBI grant
- addr_i  in  NUM_PORTS x ADDR_WIDTH  request address
- we_i  in  NUM_PORTS  write enable
- be_i  in  NUM_PORTS x 4  byte enables
- wdata_i  in  NUM_PORTS x DATA_WIDTH  write data
- rvalid_o  out  NUM_PORTS  response valid
- rdata_o  out  NUM_PORTS x DATA_WIDTH  read data
- err_o  out  NUM_PORTS  response error, qualified by rvalid_o
- haddr_o, htrans_o[1:0], hwrite_o, hsize_o[2:0], hburst_o[2:0], hprot_o[3:0], hwdata_o  out  AHB-Lite master outputs
- hrdata_i, hready_i, hresp_i  in  AHB-Lite master inputs

## Operation
- Address stage: arbiter selects one requesting port; drives haddr/hwrite/hsize/hprot, htrans=NONSEQ, hburst=SINGLE. Only NONSEQ and IDLE used.
- Selection locked while htrans=NONSEQ and hready_i=0 (address must stay stable); arbiter re-evaluates only in cycles with hready_i=1.
- gnt_o[p]=1 exactly in the cycle htrans=NONSEQ, selected=p, hready_i=1, hresp_i=0.
- Data stage register: port id, we, wdata captured at grant; hwdata_o driven from it during data phase.
- be -> hsize/haddr[1:0]: 1111 word, addr[1:0]=00; 0011/1100 half, addr[1:0]=00/10; one-hot byte, addr[1:0]=bit index. Any other pattern issued as word at aligned address.
- hprot_o = 4'b0010 for INSTR_PORT_MASK ports, 4'b0011 otherwise.
- Completion: data phase ends on hready_i=1; next cycle rvalid_o[port]=1, rdata_o[port]=registered hrdata_i (0 for writes), err_o=hresp_i.
- ERROR response: first cycle (hresp_i=1, hready_i=0) bridge drives htrans=IDLE, pending address-phase request not granted and re-presented after; second cycle completes with err_o=1.
- Round robin: pointer moves to port after the granted one on each gnt; fixed priority has no state.
- Non-selected ports see gnt_o=0 and must hold their request (OBI rule).

## Timing
- Reset values: gnt_o, rvalid_o, err_o, rdata_o = 0; htrans_o=IDLE; haddr/hwrite/hsize/hburst/hprot/hwdata = 0; RR pointer = 0; data stage empty.
- Zero-wait read: req cycle 0 -> gnt cycle 0 -> data phase cycle 1 -> rvalid cycle 2. Each AHB wait state adds one cycle.
- Back-to-back: new grant possible every cycle with hready_i=1 (address of N+1 overlaps data of N).
- Simultaneous requests, ARB_MODE=0: lowest index granted; ARB_MODE=1: first requester at/after pointer.
- Reset mid-transfer: all state cleared asynchronously; in-flight response discarded, no rvalid.
- No requests: htrans=IDLE, outputs hold previous address fields.

## Structure
- Package cv32e40p_ahb_pkg: htrans/hsize/hburst enums, HPROT constants, be_to_size function returning size and addr offset.
- Sub-module cv32e40p_rr_arbiter (NUM_PORTS, MODE): req vector, advance strobe -> one-hot select; bridge holds lock externally.

## Test plan
- Single read port 1, addr 0x100, zero waits, hrdata 0xDEADBEEF -> gnt cycle 0, rvalid_o[1] cycle 2, rdata 0xDEADBEEF, err 0.
- Write be=0100, addr 0x203 -> haddr 0x202? no: haddr 0x202 byte index 2 -> haddr 0x202, hsize BYTE, hwdata = wdata in data phase.
- hready_i low 3 cycles during address phase -> haddr/htrans stable, gnt only on cycle hready_i=1.
- Both ports request continuously, ARB_MODE=1 -> grants alternate 0,1,0,1; ARB_MODE=0 -> port 0 only.
- Two-cycle ERROR on data read with port 0 pending -> htrans IDLE in first error cycle, rvalid_o[1]=1 err_o[1]=1, port 0 granted afterwards.
- rst_i pulse during wait-stated read -> all outputs reset values next edge, no rvalid.

Source files
------------

// File: rtl/cv32e40p_ahb_pkg.sv
// Shared AHB-Lite encodings and the OBI byte-enable to HSIZE/offset translation
// used by the CV32E40P OBI-to-AHB bridge.
package cv32e40p_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001
  } hburst_e;

  typedef enum logic {
    DP_IDLE,
    DP_BUSY
  } dp_state_e;

  localparam logic [3:0] HPROT_OPCODE = 4'b0010;
  localparam logic [3:0] HPROT_DATA   = 4'b0011;

  typedef struct packed {
    hsize_e     size;
    logic [1:0] offset;
  } be_xlat_t;

  // Patterns that are not a natural byte/half/word lane set go out as an aligned word.
  function automatic be_xlat_t be_to_size(input logic [3:0] be);
    be_xlat_t r;
    r.size   = HSIZE_WORD;
    r.offset = 2'b00;
    case (be)
      4'b0011: begin r.size = HSIZE_HALF; r.offset = 2'b00; end
      4'b1100: begin r.size = HSIZE_HALF; r.offset = 2'b10; end
      4'b0001: begin r.size = HSIZE_BYTE; r.offset = 2'b00; end
      4'b0010: begin r.size = HSIZE_BYTE; r.offset = 2'b01; end
      4'b0100: begin r.size = HSIZE_BYTE; r.offset = 2'b10; end
      4'b1000: begin r.size = HSIZE_BYTE; r.offset = 2'b11; end
      default: begin r.size = HSIZE_WORD; r.offset = 2'b00; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cv32e40p_rr_arbiter.sv
// Request arbiter: fixed priority (MODE 0, lowest index wins) or round robin
// (MODE 1, first requester at/after a pointer that moves past each granted port).
module cv32e40p_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned MODE      = 0,
  localparam int unsigned IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 advance_i,
  output logic [NUM_PORTS-1:0] sel_o,
  output logic [IDX_W-1:0]     sel_idx_o,
  output logic                 valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;
  int unsigned      base;

  always_comb begin
    sel_o     = '0;
    sel_idx_o = '0;
    valid_o   = 1'b0;
    cand      = '0;
    base      = (MODE == 1) ? 32'(ptr_q) : 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'((base + i) % NUM_PORTS);
      if (!valid_o && req_i[cand]) begin
        sel_o[cand] = 1'b1;
        sel_idx_o   = cand;
        valid_o     = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if ((MODE == 1) && advance_i && valid_o) begin
      ptr_d = (sel_idx_o == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cv32e40p_obi_ahb_bridge.sv
// Multi-port OBI request/grant/rvalid to single AHB-Lite master bridge with
// arbitration, pipelined address/data phases, wait states and error responses.
module cv32e40p_obi_ahb_bridge
  import cv32e40p_ahb_pkg::*;
#(
  parameter int unsigned          NUM_PORTS       = 2,
  parameter int unsigned          ADDR_WIDTH      = 32,
  parameter int unsigned          DATA_WIDTH      = 32,
  parameter int unsigned          ARB_MODE        = 0,
  parameter logic [NUM_PORTS-1:0] INSTR_PORT_MASK = 'b01
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_PORTS-1:0]            req_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*4-1:0]          be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_PORTS-1:0]            err_o,
  output logic [ADDR_WIDTH-1:0]           haddr_o,
  output logic [1:0]                      htrans_o,
  output logic                            hwrite_o,
  output logic [2:0]                      hsize_o,
  output logic [2:0]                      hburst_o,
  output logic [3:0]                      hprot_o,
  output logic [DATA_WIDTH-1:0]           hwdata_o,
  input  logic [DATA_WIDTH-1:0]           hrdata_i,
  input  logic                            hready_i,
  input  logic                            hresp_i
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] arb_req, arb_sel;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 nonseq, fire;

  logic                 lock_q, lock_d;
  logic [IDX_W-1:0]     lock_idx_q, lock_idx_d;

  logic [ADDR_WIDTH-1:0] sel_addr;
  be_xlat_t              xlat;

  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  hsize_e                hsize_q, hsize_d;
  logic [3:0]            hprot_q, hprot_d;

  dp_state_e             dp_state_q, dp_state_d;
  logic [IDX_W-1:0]      dp_port_q, dp_port_d;
  logic                  dp_we_q, dp_we_d;
  logic [DATA_WIDTH-1:0] dp_wdata_q, dp_wdata_d;

  logic [NUM_PORTS-1:0]            rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0]            err_q, err_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata_q, rdata_d;

  // A stalled NONSEQ must keep its address, so only the locked port is offered to the arbiter.
  always_comb begin
    arb_req = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      arb_req[i] = lock_q ? (IDX_W'(i) == lock_idx_q) : req_i[i];
    end
  end

  cv32e40p_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .MODE      (ARB_MODE)
  ) u_arbiter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (arb_req),
    .advance_i (fire),
    .sel_o     (arb_sel),
    .sel_idx_o (arb_idx),
    .valid_o   (arb_valid)
  );

  // Both ERROR cycles drive IDLE; the pending request is re-presented afterwards.
  assign nonseq   = arb_valid & ~hresp_i & ~rst_i;
  assign fire     = nonseq & hready_i;
  assign gnt_o    = fire ? arb_sel : '0;
  assign sel_addr = addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign xlat     = be_to_size(be_i[arb_idx*4 +: 4]);

  always_comb begin
    lock_d     = nonseq & ~hready_i;
    lock_idx_d = arb_idx;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hprot_d    = hprot_q;
    if (nonseq) begin
      haddr_d  = (sel_addr & ~ADDR_WIDTH'(3)) | ADDR_WIDTH'(xlat.offset);
      hwrite_d = we_i[arb_idx];
      hsize_d  = xlat.size;
      hprot_d  = INSTR_PORT_MASK[arb_idx] ? HPROT_OPCODE : HPROT_DATA;
    end
  end

  assign htrans_o = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o  = haddr_d;
  assign hwrite_o = hwrite_d;
  assign hsize_o  = hsize_d;
  assign hburst_o = HBURST_SINGLE;
  assign hprot_o  = hprot_d;
  assign hwdata_o = dp_wdata_q;

  always_comb begin
    dp_state_d = dp_state_q;
    dp_port_d  = dp_port_q;
    dp_we_d    = dp_we_q;
    dp_wdata_d = dp_wdata_q;
    rvalid_d   = '0;
    err_d      = '0;
    rdata_d    = rdata_q;
    if (hready_i) begin
      if (dp_state_q == DP_BUSY) begin
        rvalid_d[dp_port_q] = 1'b1;
        err_d[dp_port_q]    = hresp_i;
        rdata_d[dp_port_q*DATA_WIDTH +: DATA_WIDTH] = dp_we_q ? '0 : hrdata_i;
      end
      if (fire) begin
        dp_state_d = DP_BUSY;
        dp_port_d  = arb_idx;
        dp_we_d    = we_i[arb_idx];
        dp_wdata_d = wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        dp_state_d = DP_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= HSIZE_BYTE;
      hprot_q    <= '0;
      dp_state_q <= DP_IDLE;
      dp_port_q  <= '0;
      dp_we_q    <= 1'b0;
      dp_wdata_q <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hprot_q    <= hprot_d;
      dp_state_q <= dp_state_d;
      dp_port_q  <= dp_port_d;
      dp_we_q    <= dp_we_d;
      dp_wdata_q <= dp_wdata_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_cv32e40p_obi_ahb_bridge.sv
// Bench for the OBI-to-AHB bridge: table-driven single transfers, directed
// wait/arbitration/error/reset sequences, and a randomized run against a memory model.
module tb_cv32e40p_obi_ahb_bridge;

  localparam int unsigned NP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]    req, we;
  logic [NP*32-1:0] addr, wdata;
  logic [NP*4-1:0]  be;
  logic [31:0]      hrdata;
  logic             hready, hresp;

  logic [NP-1:0]    gnt, rvalid, err;
  logic [NP*32-1:0] rdata;
  logic [31:0]      haddr, hwdata;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize, hburst;
  logic [3:0]       hprot;

  logic [NP-1:0]    r_gnt, r_rvalid, r_err;
  logic [NP*32-1:0] r_rdata;
  logic [31:0]      r_haddr, r_hwdata;
  logic [1:0]       r_htrans;
  logic             r_hwrite;
  logic [2:0]       r_hsize, r_hburst;
  logic [3:0]       r_hprot;

  cv32e40p_obi_ahb_bridge #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                            .ARB_MODE(0), .INSTR_PORT_MASK(2'b01)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .haddr_o(haddr), .htrans_o(htrans), .hwrite_o(hwrite), .hsize_o(hsize),
    .hburst_o(hburst), .hprot_o(hprot), .hwdata_o(hwdata),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp));

  cv32e40p_obi_ahb_bridge #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                            .ARB_MODE(1), .INSTR_PORT_MASK(2'b01)) dut_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(r_gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(r_rvalid), .rdata_o(r_rdata), .err_o(r_err),
    .haddr_o(r_haddr), .htrans_o(r_htrans), .hwrite_o(r_hwrite), .hsize_o(r_hsize),
    .hburst_o(r_hburst), .hprot_o(r_hprot), .hwdata_o(r_hwdata),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp));

  int unsigned n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
    req[p] = r; we[p] = w; be[p*4 +: 4] = b; addr[p*32 +: 32] = a; wdata[p*32 +: 32] = d;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; req = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
    #1;
    chk("rst gnt", gnt, 0);       chk("rst rvalid", rvalid, 0);
    chk("rst err", err, 0);       chk("rst rdata", rdata, 0);
    chk("rst htrans", htrans, 0); chk("rst haddr", haddr, 0);
    chk("rst hwrite", hwrite, 0); chk("rst hsize", hsize, 0);
    chk("rst hburst", hburst, 0); chk("rst hprot", hprot, 0);
    chk("rst hwdata", hwdata, 0); chk("rst rr gnt", r_gnt, 0);
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    int         port;
    logic       w;
    logic [3:0] b;
    logic [31:0] a, d, rd, exp_haddr;
    logic [2:0] exp_hsize;
    logic [3:0] exp_hprot;
  } vec_t;
  vec_t vt[9];

  // Reference memory (written from OBI intent) and slave memory (written from AHB signals).
  logic [7:0]  ref_mem[64];
  logic [7:0]  sl_mem[64];
  logic [31:0] expq0[$], expq1[$];
  logic        act[NP];
  logic        sl_pend, sl_wr, prev_wait;
  logic [5:0]  sl_a;
  logic [2:0]  sl_sz;
  logic [31:0] prev_haddr, e;
  logic [3:0]  be_tab[8];

  function automatic logic [31:0] sl_word(input logic [5:0] a);
    logic [5:0] w;
    w = {a[5:2], 2'b00};
    return {sl_mem[w+3], sl_mem[w+2], sl_mem[w+1], sl_mem[w]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [5:0] a);
    logic [5:0] w;
    w = {a[5:2], 2'b00};
    return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req = '0; we = '0; be = '0; addr = '0; wdata = '0;
    hrdata = '0; hready = 1'b1; hresp = 1'b0;
    vt[0] = '{1, 1'b0, 4'b1111, 32'h100, 32'h0,         32'hDEADBEEF, 32'h100,  3'd2, 4'b0011};
    vt[1] = '{1, 1'b1, 4'b0100, 32'h203, 32'hA5A51234, 32'h55AA55AA, 32'h202,  3'd0, 4'b0011};
    vt[2] = '{0, 1'b0, 4'b1111, 32'h1004, 32'h0,        32'h12345678, 32'h1004, 3'd2, 4'b0010};
    vt[3] = '{1, 1'b0, 4'b1100, 32'h301, 32'h0,         32'h0BADF00D, 32'h302,  3'd1, 4'b0011};
    vt[4] = '{1, 1'b1, 4'b0011, 32'h403, 32'hCAFE0001, 32'h11111111, 32'h400,  3'd1, 4'b0011};
    vt[5] = '{1, 1'b0, 4'b1000, 32'h500, 32'h0,         32'h87654321, 32'h503,  3'd0, 4'b0011};
    vt[6] = '{1, 1'b0, 4'b0001, 32'h507, 32'h0,         32'h00FF00FF, 32'h504,  3'd0, 4'b0011};
    vt[7] = '{1, 1'b1, 4'b0110, 32'h602, 32'h13572468, 32'h22222222, 32'h600,  3'd2, 4'b0011};
    vt[8] = '{0, 1'b0, 4'b0010, 32'h7FC, 32'h0,         32'hFEEDFACE, 32'h7FD,  3'd0, 4'b0010};

    do_reset();

    // Single zero-wait transfers from the table
    for (int i = 0; i < 9; i++) begin
      tick();
      req = '0;
      set_port(vt[i].port, 1'b1, vt[i].w, vt[i].b, vt[i].a, vt[i].d);
      hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
      #1;
      chk($sformatf("v%0d gnt", i), gnt, 64'd1 << vt[i].port);
      chk($sformatf("v%0d htrans", i), htrans, 2);
      chk($sformatf("v%0d haddr", i), haddr, vt[i].exp_haddr);
      chk($sformatf("v%0d hsize", i), hsize, vt[i].exp_hsize);
      chk($sformatf("v%0d hwrite", i), hwrite, vt[i].w);
      chk($sformatf("v%0d hprot", i), hprot, vt[i].exp_hprot);
      chk($sformatf("v%0d hburst", i), hburst, 0);
      tick();
      req = '0; hrdata = vt[i].rd;
      #1;
      chk($sformatf("v%0d dphase htrans", i), htrans, 0);
      chk($sformatf("v%0d dphase rvalid", i), rvalid, 0);
      if (vt[i].w) chk($sformatf("v%0d hwdata", i), hwdata, vt[i].d);
      tick();
      hrdata = $urandom;
      #1;
      chk($sformatf("v%0d rvalid", i), rvalid, 64'd1 << vt[i].port);
      chk($sformatf("v%0d rdata", i), rdata[vt[i].port*32 +: 32], vt[i].w ? 32'h0 : vt[i].rd);
      chk($sformatf("v%0d err", i), err, 0);
    end

    // Wait states while a new address is pending; selection stays locked
    tick(); req = '0; set_port(1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0); hready = 1'b1; #1;
    chk("ws first gnt", gnt, 2'b10);
    tick(); set_port(1, 1'b1, 1'b0, 4'hF, 32'h140, 32'h0); hready = 1'b0; #1;
    chk("ws1 htrans", htrans, 2); chk("ws1 haddr", haddr, 32'h140); chk("ws1 gnt", gnt, 0);
    tick(); set_port(0, 1'b1, 1'b0, 4'hF, 32'h040, 32'h0); #1;
    chk("ws2 htrans", htrans, 2); chk("ws2 haddr", haddr, 32'h140); chk("ws2 gnt", gnt, 0);
    tick(); #1;
    chk("ws3 htrans", htrans, 2); chk("ws3 haddr", haddr, 32'h140); chk("ws3 gnt", gnt, 0);
    tick(); hready = 1'b1; hrdata = 32'h1111; #1;
    chk("ws end gnt", gnt, 2'b10); chk("ws end haddr", haddr, 32'h140);
    chk("ws no early rvalid", rvalid, 0);
    tick(); req[1] = 1'b0; hrdata = 32'h2222; #1;
    chk("ws p0 gnt", gnt, 2'b01); chk("ws p0 haddr", haddr, 32'h040);
    chk("ws rvalid A", rvalid, 2'b10); chk("ws rdata A", rdata[32 +: 32], 32'h1111);
    tick(); req[0] = 1'b0; hrdata = 32'h3333; #1;
    chk("ws rvalid B", rvalid, 2'b10); chk("ws rdata B", rdata[32 +: 32], 32'h2222);
    chk("ws idle htrans", htrans, 0); chk("ws idle haddr hold", haddr, 32'h040);
    tick(); #1;
    chk("ws rvalid C", rvalid, 2'b01); chk("ws rdata C", rdata[31:0], 32'h3333);

    // Continuous requests from both ports: fixed vs round robin
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      set_port(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
      set_port(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      hready = 1'b1; hrdata = 32'h0;
      #1;
      chk($sformatf("fixed gnt %0d", i), gnt, 2'b01);
      chk($sformatf("rr gnt %0d", i), r_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    tick(); req = '0;
    tick(); tick();

    // Two-cycle ERROR on a port 1 read with port 0 pending
    tick(); set_port(1, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0); req[0] = 1'b0;
    hready = 1'b1; hresp = 1'b0; #1;
    chk("err first gnt", gnt, 2'b10);
    tick(); req[1] = 1'b0; set_port(0, 1'b1, 1'b0, 4'hF, 32'h080, 32'h0);
    hready = 1'b0; hresp = 1'b1; hrdata = 32'hBAD0BAD0; #1;
    chk("err c1 htrans", htrans, 0); chk("err c1 gnt", gnt, 0);
    tick(); hready = 1'b1; hresp = 1'b1; #1;
    chk("err c2 htrans", htrans, 0); chk("err c2 gnt", gnt, 0);
    tick(); hresp = 1'b0; hrdata = 32'h0; #1;
    chk("err rvalid", rvalid, 2'b10); chk("err err", err, 2'b10);
    chk("err rdata", rdata[32 +: 32], 32'hBAD0BAD0);
    chk("err retry gnt", gnt, 2'b01); chk("err retry htrans", htrans, 2);
    chk("err retry haddr", haddr, 32'h080);
    tick(); req[0] = 1'b0; hrdata = 32'h4444; #1;
    chk("err after rvalid", rvalid, 0); chk("err after err", err, 0);
    tick(); #1;
    chk("err p0 rvalid", rvalid, 2'b01); chk("err p0 rdata", rdata[31:0], 32'h4444);
    chk("err p0 err", err, 0);

    // Reset during a wait-stated read discards the response
    tick(); set_port(1, 1'b1, 1'b0, 4'hF, 32'h500, 32'hCAFE); hready = 1'b1; #1;
    chk("rmid gnt", gnt, 2'b10);
    tick(); req = '0; hready = 1'b0; #1;
    tick(); #1;
    rst = 1'b1; #1;
    chk("rmid htrans", htrans, 0); chk("rmid haddr", haddr, 0);
    chk("rmid hwdata", hwdata, 0); chk("rmid rvalid", rvalid, 0);
    tick(); hready = 1'b1; hrdata = 32'h9999;
    tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk($sformatf("rmid no rvalid %0d", i), rvalid, 0);
    end

    // Randomized traffic against a byte-addressed memory model
    be_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6};
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 8'($urandom); sl_mem[i] = ref_mem[i];
    end
    for (int p = 0; p < NP; p++) act[p] = 1'b0;
    sl_pend = 1'b0; sl_wr = 1'b0; sl_a = '0; sl_sz = '0; prev_wait = 1'b0; prev_haddr = '0;
    req = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int p = 0; p < NP; p++) begin
        if (!act[p]) begin
          if (cyc < 2600 && $urandom_range(0, 2) == 0) begin
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), be_tab[$urandom_range(0, 7)],
                     {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))}, $urandom);
            act[p] = 1'b1;
          end else begin
            req[p] = 1'b0;
          end
        end
      end
      hresp  = 1'b0;
      hready = sl_pend ? ($urandom_range(0, 3) != 0) : 1'b1;
      hrdata = (sl_pend && !sl_wr) ? sl_word(sl_a) : $urandom;
      #1;
      if (prev_wait) begin
        chk("rnd hold htrans", htrans, 2);
        chk("rnd hold haddr", haddr, prev_haddr);
      end
      chk("rnd gnt to requester", gnt & ~req, 0);
      for (int p = 0; p < NP; p++) begin
        if (rvalid[p]) begin
          if ((p == 0 && expq0.size() == 0) || (p == 1 && expq1.size() == 0)) begin
            chk($sformatf("rnd unexpected rvalid p%0d", p), rvalid[p], 0);
          end else begin
            e = (p == 0) ? expq0.pop_front() : expq1.pop_front();
            chk($sformatf("rnd rdata p%0d", p), rdata[p*32 +: 32], e);
            chk($sformatf("rnd err p%0d", p), err[p], 0);
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (gnt[p]) begin
          logic [5:0] a;
          logic [3:0] b;
          a = addr[p*32 +: 6];
          b = be[p*4 +: 4];
          if (we[p]) begin
            e = 32'h0;
            for (int k = 0; k < 4; k++) begin
              if (b[k] || !(b inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8}))
                ref_mem[{a[5:2], 2'(k)}] = wdata[p*32 + k*8 +: 8];
            end
          end else begin
            e = ref_word(a);
          end
          if (p == 0) expq0.push_back(e); else expq1.push_back(e);
          act[p] = 1'b0;
        end
      end
      if (sl_pend && hready && sl_wr) begin
        for (int k = 0; k < 4; k++) begin
          if (sl_sz == 3'd2 || (sl_sz == 3'd1 && (k / 2) == int'(sl_a[1])) ||
              (sl_sz == 3'd0 && k == int'(sl_a[1:0])))
            sl_mem[{sl_a[5:2], 2'(k)}] = hwdata[k*8 +: 8];
        end
      end
      if (hready) begin
        sl_pend = (htrans == 2'b10);
        sl_a    = haddr[5:0];
        sl_wr   = hwrite;
        sl_sz   = hsize;
      end
      prev_wait  = (htrans == 2'b10) && !hready;
      prev_haddr = haddr;
    end
    chk("rnd drain p0", expq0.size(), 0);
    chk("rnd drain p1", expq1.size(), 0);
    chk("rnd masters idle", {act[0], act[1]}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
